// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and the byte-array data RAM.
// Aligned and byte accesses go to the RAM directly; misaligned ones are split into byte-serial operations.
//   state | meaning
//   IDLE  | waiting for a request; aligned accesses use the direct path here
//   SPLIT | one unsigned-byte RAM operation per cycle for a misaligned access
//   RESP  | rsp_valid pulse; the unit does not accept a request
module mem_access_unit #(
  parameter int RAM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_u_b_h_w,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_dina,
  output logic        ram_wea,
  output logic [2:0]  ram_u_b_h_w,
  input  logic [31:0] ram_douta
);

  typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_t;

  localparam logic [32:0] RAM_LIMIT = 33'(RAM_BYTES);

  state_t      state, state_next;
  logic [2:0]  size;
  logic [32:0] last_byte;
  logic        aligned, fault, accept, direct;
  logic [31:0] base_q, wdata_q, acc_q;
  logic        word_q, uns_q, we_q;
  logic [1:0]  k_q, k_last;
  logic [31:0] split_word;
  logic [31:0] addr_hold_q, dina_hold_q;
  logic [2:0]  mode_hold_q;

  always_comb begin
    size    = 3'd1;
    aligned = 1'b1;
    if (req_u_b_h_w[1]) begin
      size    = 3'd4;
      aligned = (req_addr[1:0] == 2'b00);
    end else if (req_u_b_h_w[0]) begin
      size    = 3'd2;
      aligned = ~req_addr[0];
    end
  end

  // 33-bit sum so an address near 0xFFFFFFFF cannot wrap back into range
  assign last_byte = {1'b0, req_addr} + {30'd0, size} - 33'd1;
  assign fault     = (last_byte >= RAM_LIMIT);
  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign direct    = (state == IDLE) & req_valid & aligned & ~fault;
  assign k_last    = word_q ? 2'd3 : 2'd1;

  always_comb begin
    state_next  = state;
    ram_addr    = addr_hold_q;
    ram_dina    = dina_hold_q;
    ram_u_b_h_w = mode_hold_q;
    ram_wea     = 1'b0;
    case (state)
      IDLE: begin
        if (direct) begin
          ram_addr    = req_addr;
          ram_dina    = req_wdata;
          ram_u_b_h_w = req_u_b_h_w;
          ram_wea     = req_we & ~rst;
        end
        if (req_valid) state_next = (aligned | fault) ? RESP : SPLIT;
      end
      SPLIT: begin
        ram_addr    = base_q + {30'd0, k_q};
        ram_dina    = {24'd0, wdata_q[{k_q, 3'b000} +: 8]};
        ram_u_b_h_w = 3'b100;
        ram_wea     = we_q & ~rst;
        if (k_q == k_last) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Final load word: accumulated bytes plus the byte arriving on the last split cycle
  always_comb begin
    split_word = acc_q;
    split_word[{k_q, 3'b000} +: 8] = ram_douta[7:0];
    if (!word_q) split_word[31:16] = uns_q ? 16'h0000 : {16{split_word[15]}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_fault   <= 1'b0;
      k_q         <= '0;
      acc_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      word_q      <= 1'b0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_hold_q <= '0;
      dina_hold_q <= '0;
      mode_hold_q <= '0;
    end else begin
      state       <= state_next;
      rsp_valid   <= (state_next == RESP);
      rsp_rdata   <= '0;
      rsp_fault   <= 1'b0;
      addr_hold_q <= ram_addr;
      dina_hold_q <= ram_dina;
      mode_hold_q <= ram_u_b_h_w;
      case (state)
        IDLE: begin
          if (accept) begin
            if (fault) begin
              rsp_fault <= 1'b1;
            end else if (aligned) begin
              if (!req_we) rsp_rdata <= ram_douta;
            end else begin
              base_q  <= req_addr;
              wdata_q <= req_wdata;
              word_q  <= req_u_b_h_w[1];
              uns_q   <= req_u_b_h_w[2];
              we_q    <= req_we;
              k_q     <= 2'd0;
            end
          end
        end
        SPLIT: begin
          if (!we_q) acc_q[{k_q, 3'b000} +: 8] <= ram_douta[7:0];
          if (k_q == k_last) begin
            k_q <= 2'd0;
            if (!we_q) rsp_rdata <= split_word;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the MEM pipeline stage and the byte-array data RAM. It accepts load/store requests with a valid/ready handshake and drives the RAM port.
- Aligned accesses and byte accesses are issued to the RAM as one operation.
- Misaligned halfword and word accesses are split into byte-serial RAM operations. The unit reassembles and extends the load result.
- Out-of-range accesses are rejected with a fault and never reach the RAM.

Parameters:
- RAM_BYTES, 128: number of bytes in the data RAM. Valid addresses are 0 to RAM_BYTES-1.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_u_b_h_w  in  3  access mode: bit2 unsigned, bit1 word, bit0 half; none of bit1/bit0 set = byte
- rsp_valid  out  1  one-cycle pulse: response available
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  qualifies rsp_valid: the access was rejected
- ram_addr  out  32  RAM address
- ram_dina  out  32  RAM write data
- ram_wea  out  1  RAM write enable; RAM writes on negedge clk
- ram_u_b_h_w  out  3  RAM access mode
- ram_douta  in  32  RAM combinational read data, already extended by the RAM

Behaviour:
- Size decode:
  - bit1 set: 4 bytes. bit1 has priority over bit0.
  - else bit0 set: 2 bytes.
  - else: 1 byte.
  - bit2 is ignored for word accesses.
- Alignment: aligned when the address is a multiple of the size. Byte accesses are always aligned.
- Fault: raised when {1'b0,req_addr} + size - 1 >= RAM_BYTES.
  - The sum is computed at 33 bits, so 0xFFFFFFFF does not wrap.
  - A faulting access never asserts ram_wea.
- States: IDLE, SPLIT, RESP. Reset forces IDLE.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_fault=0, byte counter=0, accumulator=0, ram_wea=0.
- req_ready = (state==IDLE) & ~rst. A request is accepted on the posedge where req_valid & req_ready.
- IDLE, aligned, no fault (direct path):
  - ram_addr, ram_dina and ram_u_b_h_w are driven combinationally from the request.
  - ram_wea = req_valid & req_we & ~rst.
  - On a load, ram_douta is registered into rsp_rdata at the posedge.
  - Next state RESP. Latency is 1 cycle.
- IDLE, fault:
  - No RAM operation is issued.
  - Next state RESP with rsp_fault=1 and rsp_rdata=0.
- IDLE, misaligned, no fault:
  - The unit latches addr, wdata, size, unsigned and we. No RAM operation is issued this cycle.
  - Next state SPLIT with counter k=0.
- SPLIT (one cycle per byte, N = 2 or 4):
  - ram_addr = base + k.
  - ram_u_b_h_w = 3'b100 (unsigned byte).
  - ram_dina[7:0] = wdata byte k; upper bits of ram_dina are 0.
  - ram_wea = we & ~rst.
  - On a load, ram_douta[7:0] is captured into accumulator byte k.
  - k increments each cycle. When k==N-1, next state is RESP.
  - Latency is N+1 cycles.
- Load extension after SPLIT:
  - half: upper 16 bits are 0 if unsigned, else a copy of bit 15.
  - word: no extension.
  - Direct-path loads use ram_douta as-is, because the RAM already extends.
- RESP:
  - rsp_valid=1 for exactly one cycle. rsp_rdata=0 for stores.
  - Next state IDLE. req_ready is 0 in this cycle, so the minimum issue interval is 2 cycles.
- Outside direct-path IDLE and SPLIT, ram_wea=0 and ram_addr/ram_dina hold their last value. Only ram_wea carries meaning.
- Reset mid-operation:
  - ram_wea is gated by ~rst combinationally, so a reset cycle never writes.
  - The next state is IDLE, any partial split is abandoned, and no response is produced.
  - Bytes already written by earlier SPLIT cycles remain in the RAM.
- req_valid deasserted while in IDLE: no RAM write, state stays IDLE.
- Request inputs are don't-care outside the acceptance cycle.

Test Plan:
- Aligned word store of 0xDEADBEEF to 0x10, then a load word from 0x10: the store has ram_wea high for exactly 1 cycle; the load gives rsp_valid 1 cycle after acceptance with rsp_rdata=0xDEADBEEF and rsp_fault=0.
- Misaligned word store of 0x11223344 to 0x05: 4 SPLIT cycles write 0x44, 0x33, 0x22, 0x11 to addresses 0x05–0x08. A later misaligned word load from 0x05 returns 0x11223344, with rsp_valid on cycle 5 after acceptance.
- Bytes 0x03=0xFF and 0x04=0x80:
  - signed half load at 0x03 → 0xFFFF80FF;
  - unsigned half load at 0x03 → 0x000080FF;
  - each takes 3-cycle latency.
- Fault cases, each giving rsp_valid=1, rsp_fault=1, rsp_rdata=0 and no ram_wea:
  - word store at 0x7E;
  - byte load at 0x80;
  - half load at 0xFFFFFFFF.
- rst asserted on SPLIT cycle k=1 of a misaligned word store to 0x21: ram_wea=0 in the reset cycle, and only byte 0x21 is modified. The unit is in IDLE with req_ready=1 and no rsp_valid after reset.
- Back-to-back requests with req_valid held high: a second request is accepted only once req_ready returns to 1. Verify req_ready=0 through SPLIT and RESP, and that responses appear in order.
